// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the elastic pipeline-stage buffers.
//               Holds the occupancy state encoding, the per-boundary bundle
//               widths used by the pipeline top level, and the bit positions
//               of the wb and m fields inside a control bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // Occupancy doubles as the state encoding of the buffer.
  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = OCC_EMPTY,
    ST_ONE   = OCC_ONE,
    ST_FULL  = OCC_FULL
  } occ_state_e;

  // Per-boundary widths.
  // IF/ID  : ctrl = 1 live marker; data = pc+4 (32) + instruction (32).
  localparam int IFID_CTRL_W  = 1;
  localparam int IFID_DATA_W  = 64;
  // ID/EX  : ctrl = wb (2) + m (3) + ex (4);
  //          data = pc+4, rs, rt, imm (4 x 32) + rt idx (5) + rd idx (5).
  localparam int IDEX_CTRL_W  = 9;
  localparam int IDEX_DATA_W  = 138;
  // EX/MEM : ctrl = wb (2) + m (3);
  //          data = branch target (32) + alu result (32) + zero flag (1)
  //                 + store data (32) + 4 bits packed by the top level.
  localparam int EXMEM_CTRL_W = 5;
  localparam int EXMEM_DATA_W = 101;
  // MEM/WB : ctrl = wb (2); data = load data (32) + alu (32) + dest idx (5).
  localparam int MEMWB_CTRL_W = 2;
  localparam int MEMWB_DATA_W = 69;

  // Control bundle layout: wb field in the upper bits, m field below it.
  localparam int WB_REG_WRITE_BIT  = 4;
  localparam int WB_MEM_TO_REG_BIT = 3;
  localparam int M_BRANCH_BIT      = 2;
  localparam int M_MEM_READ_BIT    = 1;
  localparam int M_MEM_WRITE_BIT   = 0;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_slot
// Description : One clock-enabled storage slot holding a control bundle and
//               a data bundle. The control part can be cleared independently
//               of the data part so a bubble can be inserted cheaply.
// Ports       : clock      - rising-edge clock
//               reset      - synchronous active-low reset (clears everything)
//               load       - capture d_ctrl/d_data
//               clear_ctrl - zero the control part (wins over load)
//               clear_data - zero the data part (wins over load)
//               d_ctrl/d_data - incoming bundles
//               q_ctrl/q_data - stored bundles
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot #(
  parameter int CTRL_W = 5,
  parameter int DATA_W = 101
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              clear_ctrl,
  input  logic              clear_data,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [DATA_W-1:0] q_data
);

  logic [CTRL_W-1:0] ctrl_reg;
  logic [DATA_W-1:0] data_reg;

  always_ff @(posedge clock) begin
    if (!reset) begin
      ctrl_reg <= '0;
      data_reg <= '0;
    end else begin
      if (clear_ctrl) begin
        ctrl_reg <= '0;
      end else if (load) begin
        ctrl_reg <= d_ctrl;
      end
      if (clear_data) begin
        data_reg <= '0;
      end else if (load) begin
        data_reg <= d_data;
      end
    end
  end

  assign q_ctrl = ctrl_reg;
  assign q_data = data_reg;

endmodule : pipe_slot
`default_nettype wire

// File: rtl/pipe_stage_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_buffer
// Description : Elastic pipeline-stage register with a valid/ready handshake
//               and a 2-entry skid buffer. up_ready and dn_valid are both
//               flops, so neither side sees a combinational path from the
//               other. A flush empties the buffer and forces dn_ctrl to zero.
// Ports       : clock, reset (sync, active-low), flush
//               up_valid/up_ready/up_ctrl/up_data - upstream side
//               dn_valid/dn_ready/dn_ctrl/dn_data - downstream side
//               occupancy - entries held (0, 1 or 2)
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_buffer
  import pipe_pkg::*;
#(
  parameter int CTRL_W              = EXMEM_CTRL_W,
  parameter int DATA_W              = EXMEM_DATA_W,
  parameter int CLEAR_DATA_ON_FLUSH = 0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [CTRL_W-1:0] up_ctrl,
  input  logic [DATA_W-1:0] up_data,
  output logic              dn_valid,
  input  logic              dn_ready,
  output logic [CTRL_W-1:0] dn_ctrl,
  output logic [DATA_W-1:0] dn_data,
  output logic [1:0]        occupancy
);

  occ_state_e state_q, state_d;
  logic       up_ready_q;
  logic       dn_valid_q;

  logic up_fire;
  logic dn_fire;

  // Slot control
  logic main_load;
  logic main_from_skid;
  logic main_clear_ctrl;
  logic main_clear_data;
  logic skid_load;

  logic [CTRL_W-1:0] main_d_ctrl, main_q_ctrl, skid_q_ctrl;
  logic [DATA_W-1:0] main_d_data, main_q_data, skid_q_data;

  // Handshakes use only registered flags on the local side.
  assign up_fire = up_valid & up_ready_q;
  assign dn_fire = dn_valid_q & dn_ready;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= ST_EMPTY;
      up_ready_q <= 1'b1;
      dn_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      up_ready_q <= (state_d != ST_FULL);
      dn_valid_q <= (state_d != ST_EMPTY);
    end
  end

  always_comb begin
    state_d         = state_q;
    main_load       = 1'b0;
    main_from_skid  = 1'b0;
    main_clear_ctrl = 1'b0;
    main_clear_data = 1'b0;
    skid_load       = 1'b0;

    if (flush) begin
      // Kill everything; an upstream entry offered this cycle is dropped.
      state_d         = ST_EMPTY;
      main_clear_ctrl = 1'b1;
      main_clear_data = (CLEAR_DATA_ON_FLUSH != 0);
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (up_fire) begin
            main_load = 1'b1;
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (up_fire && dn_fire) begin
            main_load = 1'b1;
          end else if (up_fire) begin
            // Downstream stalled: park the newcomer behind the main entry.
            skid_load = 1'b1;
            state_d   = ST_FULL;
          end else if (dn_fire) begin
            // Leave a bubble; data is left as is to keep the data path lean.
            main_clear_ctrl = 1'b1;
            state_d         = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (dn_fire) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ST_ONE;
          end
        end
        default: begin
          state_d         = ST_EMPTY;
          main_clear_ctrl = 1'b1;
        end
      endcase
    end
  end

  assign main_d_ctrl = main_from_skid ? skid_q_ctrl : up_ctrl;
  assign main_d_data = main_from_skid ? skid_q_data : up_data;

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clock      (clock),
    .reset      (reset),
    .load       (main_load),
    .clear_ctrl (main_clear_ctrl),
    .clear_data (main_clear_data),
    .d_ctrl     (main_d_ctrl),
    .d_data     (main_d_data),
    .q_ctrl     (main_q_ctrl),
    .q_data     (main_q_data)
  );

  // The skid slot is never cleared outside reset: a stale entry there is
  // harmless because it is always rewritten before being promoted.
  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clock      (clock),
    .reset      (reset),
    .load       (skid_load),
    .clear_ctrl (1'b0),
    .clear_data (1'b0),
    .d_ctrl     (up_ctrl),
    .d_data     (up_data),
    .q_ctrl     (skid_q_ctrl),
    .q_data     (skid_q_data)
  );

  assign up_ready  = up_ready_q;
  assign dn_valid  = dn_valid_q;
  assign dn_ctrl   = main_q_ctrl;
  assign dn_data   = main_q_data;
  assign occupancy = state_q;

endmodule : pipe_stage_buffer
`default_nettype wire

// File: tb/tb_pipe_stage_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_buffer
// Description : Directed and randomised checks of pipe_stage_buffer. Two
//               instances share all inputs: one holds data on flush, the
//               other clears it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_buffer;

  localparam int CW = 5;
  localparam int DW = 101;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic          up_valid;
  logic [CW-1:0] up_ctrl;
  logic [DW-1:0] up_data;
  logic          dn_ready;

  logic          up_ready0, dn_valid0, up_ready1, dn_valid1;
  logic [CW-1:0] dn_ctrl0, dn_ctrl1;
  logic [DW-1:0] dn_data0, dn_data1;
  logic [1:0]    occ0, occ1;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pipe_stage_buffer #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA_ON_FLUSH(0)) u_dut0 (
    .clock(clock), .reset(reset), .flush(flush),
    .up_valid(up_valid), .up_ready(up_ready0), .up_ctrl(up_ctrl), .up_data(up_data),
    .dn_valid(dn_valid0), .dn_ready(dn_ready), .dn_ctrl(dn_ctrl0), .dn_data(dn_data0),
    .occupancy(occ0)
  );

  pipe_stage_buffer #(.CTRL_W(CW), .DATA_W(DW), .CLEAR_DATA_ON_FLUSH(1)) u_dut1 (
    .clock(clock), .reset(reset), .flush(flush),
    .up_valid(up_valid), .up_ready(up_ready1), .up_ctrl(up_ctrl), .up_data(up_data),
    .dn_valid(dn_valid1), .dn_ready(dn_ready), .dn_ctrl(dn_ctrl1), .dn_data(dn_data1),
    .occupancy(occ1)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic offer(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic rdy);
    up_valid = v;
    up_ctrl  = c;
    up_data  = d;
    dn_ready = rdy;
  endtask

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } entry_t;

  entry_t q[$];

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    offer(1'b0, '0, '0, 1'b0);
    step();
    step();

    // Reset state
    reset = 1'b1;
    check("rst_up_ready", up_ready0, 1);
    check("rst_dn_valid", dn_valid0, 0);
    check("rst_dn_ctrl", dn_ctrl0, 0);
    check("rst_dn_data", dn_data0, 0);
    check("rst_occ", occ0, 0);

    // First entry: one-cycle latency
    offer(1'b1, 5'h1B, 101'h5, 1'b1);
    step();
    check("first_valid", dn_valid0, 1);
    check("first_ctrl", dn_ctrl0, 5'h1B);
    check("first_data", dn_data0, 5);
    check("first_occ", occ0, 1);
    offer(1'b0, '0, '0, 1'b1);
    step();
    check("drain_valid", dn_valid0, 0);
    check("drain_ctrl", dn_ctrl0, 0);
    check("drain_data_held", dn_data0, 5);

    // Full throughput
    for (int i = 0; i < 8; i++) begin
      offer(1'b1, CW'(i), DW'(i), 1'b1);
      step();
      check("tput_data", dn_data0, i);
      check("tput_ctrl", dn_ctrl0, i);
      check("tput_occ", occ0, 1);
      check("tput_up_ready", up_ready0, 1);
    end
    offer(1'b0, '0, '0, 1'b1);
    step();
    check("tput_empty", occ0, 0);

    // Backpressure into the skid slot
    offer(1'b1, 5'd1, 101'd1, 1'b0);
    step();
    check("bp_a_data", dn_data0, 1);
    check("bp_a_occ", occ0, 1);
    offer(1'b1, 5'd2, 101'd2, 1'b0);
    step();
    check("bp_full_occ", occ0, 2);
    check("bp_full_up_ready", up_ready0, 0);
    check("bp_a_still", dn_data0, 1);
    offer(1'b1, 5'd3, 101'd3, 1'b0);
    step();
    check("bp_hold_data", dn_data0, 1);
    check("bp_hold_ctrl", dn_ctrl0, 1);
    check("bp_hold_occ", occ0, 2);
    offer(1'b1, 5'd3, 101'd3, 1'b1);
    step();
    check("bp_b_data", dn_data0, 2);
    check("bp_b_occ", occ0, 1);
    check("bp_b_up_ready", up_ready0, 1);
    step();
    check("bp_c_data", dn_data0, 3);
    check("bp_c_ctrl", dn_ctrl0, 3);
    offer(1'b0, '0, '0, 1'b1);
    step();
    check("bp_end_valid", dn_valid0, 0);
    check("bp_end_occ", occ0, 0);

    // Flush from FULL with a concurrent upstream offer
    offer(1'b1, 5'd7, 101'h11, 1'b0);
    step();
    offer(1'b1, 5'd7, 101'h12, 1'b0);
    step();
    check("fl_pre_occ", occ0, 2);
    flush = 1'b1;
    offer(1'b1, 5'd9, 101'd9, 1'b0);
    step();
    check("fl_valid", dn_valid0, 0);
    check("fl_ctrl", dn_ctrl0, 0);
    check("fl_occ", occ0, 0);
    check("fl_up_ready", up_ready0, 1);
    check("fl_hold_data", dn_data0, 101'h11);
    check("fl_clear_data", dn_data1, 0);
    check("fl_clear_ctrl1", dn_ctrl1, 0);
    step();
    check("fl_b2b_occ", occ0, 0);
    flush = 1'b0;
    offer(1'b0, '0, '0, 1'b1);
    step();
    check("fl_no_ghost", dn_valid0, 0);

    // Flush and reset together: reset wins, data zeroed even when held on flush
    offer(1'b1, 5'd4, 101'h44, 1'b0);
    step();
    check("fr_pre_data", dn_data0, 101'h44);
    flush = 1'b1;
    reset = 1'b0;
    step();
    check("fr_data", dn_data0, 0);
    check("fr_occ", occ0, 0);
    check("fr_up_ready", up_ready0, 1);
    flush = 1'b0;
    reset = 1'b1;
    offer(1'b0, '0, '0, 1'b0);
    step();
    check("fr_post_occ", occ0, 0);

    // Random traffic against a queue model
    q.delete();
    for (int n = 0; n < 3000; n++) begin
      logic exp_ur;
      entry_t e;
      exp_ur = (q.size() < 2);
      check("rnd_occ", occ0, q.size());
      check("rnd_up_ready", up_ready0, exp_ur);
      check("rnd_dn_valid", dn_valid0, q.size() > 0);
      if (q.size() > 0) begin
        check("rnd_ctrl", dn_ctrl0, q[0].c);
        check("rnd_data", dn_data0, q[0].d);
      end else begin
        check("rnd_ctrl_zero", dn_ctrl0, 0);
      end
      e.c = CW'($urandom);
      e.d = {$urandom, $urandom, $urandom, $urandom};
      offer($urandom_range(0, 3) != 0, e.c, e.d, $urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 39) == 0);
      if (flush) begin
        q.delete();
      end else begin
        if (dn_ready && q.size() > 0) void'(q.pop_front());
        if (up_valid && exp_ur) q.push_back(e);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipe_stage_buffer
`default_nettype wire
